// File: rtl/ai_pkg.sv
// ai_pkg: AXI response codes and the read-tracking entry layout shared by the dispatcher.
package ai_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    // Tracking entry packs {decerr, sel, id, len} from MSB to LSB.
    function automatic int trk_entry_w(input int sel_w, input int id_w, input int len_w);
        return 1 + sel_w + id_w + len_w;
    endfunction
endpackage

// File: rtl/ai_sync_fifo.sv
// ai_sync_fifo: synchronous FIFO with the head read straight from storage and an occupancy count.
module ai_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/ai_rd_dispatcher_dec.sv
// ai_rd_dispatcher_dec: decodes master AR to slave ports and returns R beats in AR order,
// answering unmapped addresses locally with DECERR bursts.
module ai_rd_dispatcher_dec
    import ai_pkg::*;
#(
    parameter int SLV_AMT = 4,
    parameter int OUTSTANDING_AMT = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TRANS_MST_ID_W = 5,
    parameter int TRANS_BURST_W = 2,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int TRANS_RESP_W = 2,
    parameter logic [ADDR_WIDTH*SLV_AMT-1:0] SLV_BASE = {ADDR_WIDTH*SLV_AMT{1'b0}},
    parameter logic [ADDR_WIDTH*SLV_AMT-1:0] SLV_MASK = {ADDR_WIDTH*SLV_AMT{1'b0}}
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESET_i,
    input  logic [TRANS_MST_ID_W-1:0]              m_ARID_i,
    input  logic [ADDR_WIDTH-1:0]                  m_ARADDR_i,
    input  logic [TRANS_BURST_W-1:0]               m_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]            m_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]           m_ARSIZE_i,
    input  logic                                   m_ARVALID_i,
    output logic                                   m_ARREADY_o,
    output logic [TRANS_MST_ID_W-1:0]              m_RID_o,
    output logic [DATA_WIDTH-1:0]                  m_RDATA_o,
    output logic [TRANS_RESP_W-1:0]                m_RRESP_o,
    output logic                                   m_RLAST_o,
    output logic                                   m_RVALID_o,
    input  logic                                   m_RREADY_i,
    output logic [TRANS_MST_ID_W*SLV_AMT-1:0]      sa_ARID_o,
    output logic [ADDR_WIDTH*SLV_AMT-1:0]          sa_ARADDR_o,
    output logic [TRANS_BURST_W*SLV_AMT-1:0]       sa_ARBURST_o,
    output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]    sa_ARLEN_o,
    output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]   sa_ARSIZE_o,
    output logic [SLV_AMT-1:0]                     sa_ARVALID_o,
    input  logic [SLV_AMT-1:0]                     sa_ARREADY_i,
    input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]      sa_RID_i,
    input  logic [DATA_WIDTH*SLV_AMT-1:0]          sa_RDATA_i,
    input  logic [TRANS_RESP_W*SLV_AMT-1:0]        sa_RRESP_i,
    input  logic [SLV_AMT-1:0]                     sa_RLAST_i,
    input  logic [SLV_AMT-1:0]                     sa_RVALID_i,
    output logic [SLV_AMT-1:0]                     sa_RREADY_o,
    output logic [SLV_AMT-1:0]                     sa_AR_outst_full_o,
    output logic [$clog2(OUTSTANDING_AMT):0]       outst_cnt_o
);
    localparam int SEL_W = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1;
    localparam int ENT_W = trk_entry_w(SEL_W, TRANS_MST_ID_W, TRANS_DATA_LEN_W);
    logic hit, full, empty, ar_hs, r_hs, pop, act, h_dec;
    logic [SEL_W-1:0] sel, h_sel;
    logic [TRANS_MST_ID_W-1:0] h_id;
    logic [TRANS_DATA_LEN_W-1:0] h_len, beat_cnt;
    logic [ENT_W-1:0] head;
    // Scanning downward lets the lowest matching index win.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = SLV_AMT - 1; i >= 0; i--)
            if ((m_ARADDR_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
    end
    assign m_ARREADY_o = !ARESET_i && !full && (hit ? sa_ARREADY_i[sel] : 1'b1);
    assign ar_hs = m_ARVALID_i && m_ARREADY_o;
    always_comb begin
        sa_ARVALID_o = '0;
        sa_ARVALID_o[sel] = m_ARVALID_i && hit && !full && !ARESET_i;
    end
    assign sa_ARID_o = {SLV_AMT{m_ARID_i}};
    assign sa_ARADDR_o = {SLV_AMT{m_ARADDR_i}};
    assign sa_ARBURST_o = {SLV_AMT{m_ARBURST_i}};
    assign sa_ARLEN_o = {SLV_AMT{m_ARLEN_i}};
    assign sa_ARSIZE_o = {SLV_AMT{m_ARSIZE_i}};
    assign sa_AR_outst_full_o = {SLV_AMT{full}};
    ai_sync_fifo #(.WIDTH(ENT_W), .DEPTH(OUTSTANDING_AMT)) u_trk (
        .clk(ACLK_i),
        .rst(ARESET_i),
        .push(ar_hs),
        .din({!hit, sel, m_ARID_i, m_ARLEN_i}),
        .pop(pop),
        .head(head),
        .count(outst_cnt_o),
        .full(full),
        .empty(empty)
    );
    assign {h_dec, h_sel, h_id, h_len} = head;
    // Reset also silences the R side so no beat escapes in the reset cycle.
    assign act = !empty && !ARESET_i;
    assign m_RVALID_o = act && (h_dec || sa_RVALID_i[h_sel]);
    assign m_RID_o = !act ? '0 : h_dec ? h_id : sa_RID_i[h_sel*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    assign m_RDATA_o = (!act || h_dec) ? '0 : sa_RDATA_i[h_sel*DATA_WIDTH +: DATA_WIDTH];
    assign m_RRESP_o = !act ? '0 : h_dec ? TRANS_RESP_W'(DECERR) : sa_RRESP_i[h_sel*TRANS_RESP_W +: TRANS_RESP_W];
    assign m_RLAST_o = act && (h_dec ? beat_cnt == h_len : sa_RLAST_i[h_sel]);
    always_comb begin
        sa_RREADY_o = '0;
        sa_RREADY_o[h_sel] = act && !h_dec && m_RREADY_i;
    end
    assign r_hs = m_RVALID_o && m_RREADY_i;
    assign pop = r_hs && m_RLAST_o;
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) beat_cnt <= '0;
        else if (r_hs && h_dec) beat_cnt <= m_RLAST_o ? '0 : beat_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ai_rd_dispatcher_dec.sv
// tb_ai_rd_dispatcher_dec: scoreboard bench with simple slave responders and an in-order R reference.
module tb_ai_rd_dispatcher_dec;
    localparam int N = 4, OUT = 8, DW = 32, AW = 32, IW = 5, LW = 8;
    localparam logic [AW*N-1:0] BASE = {32'h4000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    localparam logic [AW*N-1:0] MASK = {32'hC000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
    typedef struct {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} beat_t;
    typedef struct {int slv; int tag; logic [IW-1:0] id; logic [LW-1:0] len;} job_t;
    logic clk = 1'b0, rst;
    logic [IW-1:0] ar_id;
    logic [AW-1:0] ar_addr;
    logic [1:0] ar_burst;
    logic [LW-1:0] ar_len;
    logic [2:0] ar_size;
    logic ar_valid, ar_ready;
    logic [IW-1:0] r_id;
    logic [DW-1:0] r_data;
    logic [1:0] r_resp;
    logic r_last, r_valid, r_ready;
    logic [IW*N-1:0] s_arid, s_rid;
    logic [AW*N-1:0] s_araddr;
    logic [2*N-1:0] s_arburst, s_rresp;
    logic [LW*N-1:0] s_arlen;
    logic [3*N-1:0] s_arsize;
    logic [DW*N-1:0] s_rdata;
    logic [N-1:0] s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, s_full;
    logic [3:0] cnt;
    beat_t exp_q[$];
    job_t jobs[$];
    int sbeat[N];
    bit shs[N];
    bit [N-1:0] en;
    bit rv_rand, rr_force, rr_val;
    int cur_tag, exp_cnt, checks, errors;

    ai_rd_dispatcher_dec #(
        .SLV_AMT(N), .OUTSTANDING_AMT(OUT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .TRANS_MST_ID_W(IW), .TRANS_BURST_W(2), .TRANS_DATA_LEN_W(LW),
        .TRANS_DATA_SIZE_W(3), .TRANS_RESP_W(2), .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .ACLK_i(clk), .ARESET_i(rst),
        .m_ARID_i(ar_id), .m_ARADDR_i(ar_addr), .m_ARBURST_i(ar_burst), .m_ARLEN_i(ar_len),
        .m_ARSIZE_i(ar_size), .m_ARVALID_i(ar_valid), .m_ARREADY_o(ar_ready),
        .m_RID_o(r_id), .m_RDATA_o(r_data), .m_RRESP_o(r_resp), .m_RLAST_o(r_last),
        .m_RVALID_o(r_valid), .m_RREADY_i(r_ready),
        .sa_ARID_o(s_arid), .sa_ARADDR_o(s_araddr), .sa_ARBURST_o(s_arburst), .sa_ARLEN_o(s_arlen),
        .sa_ARSIZE_o(s_arsize), .sa_ARVALID_o(s_arvalid), .sa_ARREADY_i(s_arready),
        .sa_RID_i(s_rid), .sa_RDATA_i(s_rdata), .sa_RRESP_i(s_rresp), .sa_RLAST_i(s_rlast),
        .sa_RVALID_i(s_rvalid), .sa_RREADY_o(s_rready), .sa_AR_outst_full_o(s_full),
        .outst_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    function automatic int ref_dec(input logic [AW-1:0] a);
        logic [AW*N-1:0] b = BASE;
        logic [AW*N-1:0] m = MASK;
        for (int i = 0; i < N; i++)
            if ((a & m[i*AW +: AW]) == b[i*AW +: AW]) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] sdata(input int t, input int b);
        return {t[15:0], 8'h5A, b[7:0]};
    endfunction

    function automatic logic [1:0] sresp(input int t);
        return 2'(t % 3);
    endfunction

    function automatic int head_of(input int s);
        foreach (jobs[k]) if (jobs[k].slv == s) return k;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ar(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [LW-1:0] len);
        int n = 0;
        bit hs = 0;
        ar_valid = 1; ar_addr = a; ar_id = id; ar_len = len; ar_burst = 2'b01; ar_size = 3'd2;
        do begin
            @(negedge clk);
            hs = ar_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 500);
        ar_valid = 0;
        cur_tag++;
        chk("ar_handshake", 64'(hs), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || cnt != 0) && n < 3000) begin
            tick(1);
            n++;
        end
        chk("drain_beats", 64'(exp_q.size()), 64'd0);
        chk("drain_cnt", 64'(cnt), 64'd0);
    endtask

    // Monitor: compares R beats and occupancy against the reference; records slave-side handshakes.
    initial begin
        beat_t e;
        int d, k;
        forever begin
            @(negedge clk);
            chk("outst_cnt", 64'(cnt), 64'(exp_cnt));
            chk("outst_full", 64'(s_full), 64'({N{exp_cnt == OUT}}));
            if (rst) begin
                chk("rst_arready", 64'(ar_ready), 64'd0);
                chk("rst_rvalid", 64'(r_valid), 64'd0);
                chk("rst_rready", 64'(s_rready), 64'd0);
                chk("rst_arvalid", 64'(s_arvalid), 64'd0);
                exp_q.delete();
                jobs.delete();
                exp_cnt = 0;
                for (int i = 0; i < N; i++) begin
                    shs[i] = 1;
                    sbeat[i] = 0;
                end
                continue;
            end
            if (exp_cnt == OUT) chk("full_arready", 64'(ar_ready), 64'd0);
            if (ar_valid && ar_ready) begin
                d = ref_dec(ar_addr);
                chk("ar_route", 64'(s_arvalid), d < 0 ? 64'd0 : 64'd1 << d);
                for (int b = 0; b <= int'(ar_len); b++)
                    exp_q.push_back(d < 0 ? beat_t'{ar_id, '0, 2'b11, b == int'(ar_len)}
                                          : beat_t'{ar_id, sdata(cur_tag, b), sresp(cur_tag), b == int'(ar_len)});
                exp_cnt++;
            end
            for (int i = 0; i < N; i++)
                if (s_arvalid[i] && s_arready[i])
                    jobs.push_back(job_t'{i, cur_tag, s_arid[i*IW +: IW], s_arlen[i*LW +: LW]});
            for (int i = 0; i < N; i++) begin
                shs[i] = s_rvalid[i] && s_rready[i];
                k = head_of(i);
                if (shs[i] && k >= 0) begin
                    if (sbeat[i] == int'(jobs[k].len)) begin
                        jobs.delete(k);
                        sbeat[i] = 0;
                    end else sbeat[i]++;
                end
            end
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) chk("r_unexpected", 64'(r_valid), 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("rid", 64'(r_id), 64'(e.id));
                    chk("rdata", 64'(r_data), 64'(e.data));
                    chk("rresp", 64'(r_resp), 64'(e.resp));
                    chk("rlast", 64'(r_last), 64'(e.last));
                    if (e.last) exp_cnt--;
                end
            end
        end
    end

    // Slave responders and master R-ready driver; RVALID is held until accepted.
    initial begin
        int k;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                s_arready[i] = ($urandom % 4) != 0;
                if (!s_rvalid[i] || shs[i]) begin
                    k = head_of(i);
                    s_rvalid[i] = en[i] && k >= 0 && (!rv_rand || ($urandom % 3) != 0);
                    s_rid[i*IW +: IW] = k >= 0 ? jobs[k].id : '0;
                    s_rdata[i*DW +: DW] = k >= 0 ? sdata(jobs[k].tag, sbeat[i]) : '0;
                    s_rresp[i*2 +: 2] = k >= 0 ? sresp(jobs[k].tag) : 2'b00;
                    s_rlast[i] = k >= 0 && sbeat[i] == int'(jobs[k].len);
                end
            end
            r_ready = rr_force ? rr_val : (($urandom % 4) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] slv_addr [4];
        slv_addr = '{32'h0000_0100, 32'h4000_0200, 32'h8000_0300, 32'h6000_0400};
        rst = 1; en = '1; rv_rand = 0; rr_force = 0; rr_val = 0;
        ar_valid = 0; ar_addr = '0; ar_id = '0; ar_len = '0; ar_burst = '0; ar_size = '0;
        s_arready = '0; s_rvalid = '0; s_rlast = '0; s_rid = '0; s_rdata = '0; s_rresp = '0; r_ready = 0;
        tick(3);
        rst = 0;
        tick(1);
        // Slave-1 burst of 4 with RID 5
        ar(32'h4000_0010, 5'd5, 8'd3);
        chk("t1_cnt_one", 64'(cnt), 64'd1);
        wait_idle();
        // Unmapped address answered with DECERR
        ar(32'hF000_0000, 5'd7, 8'd2);
        wait_idle();
        // Slave 2 answers first but must wait behind slave 0
        en[0] = 0;
        ar(32'h0000_1000, 5'd1, 8'd1);
        ar(32'h8000_0000, 5'd2, 8'd1);
        tick(4);
        @(negedge clk);
        chk("t3_s2_valid", 64'(s_rvalid[2]), 64'd1);
        chk("t3_s2_held", 64'(s_rready[2]), 64'd0);
        @(posedge clk);
        #1;
        en[0] = 1;
        wait_idle();
        // Fill the queue, then confirm a 9th AR stalls
        en = '0;
        for (int i = 0; i < OUT; i++) ar(slv_addr[i % 4], 5'(i), 8'd0);
        chk("t4_cnt_full", 64'(cnt), 64'd8);
        chk("t4_full_flag", 64'(s_full), 64'hF);
        ar_valid = 1; ar_addr = 32'h4000_0000; ar_id = 5'd9; ar_len = 8'd0;
        tick(2);
        @(negedge clk);
        chk("t4_stall_ready", 64'(ar_ready), 64'd0);
        chk("t4_stall_valid", 64'(s_arvalid), 64'd0);
        @(posedge clk);
        #1;
        en = '1;
        ar(32'h4000_0000, 5'd9, 8'd0);
        wait_idle();
        // DECERR beat held through a master stall
        rr_force = 1; rr_val = 1;
        ar(32'hF000_0000, 5'd3, 8'd1);
        tick(1);
        rr_val = 0;
        @(negedge clk);
        chk("t5_hold_valid", 64'(r_valid), 64'd1);
        chk("t5_hold_last", 64'(r_last), 64'd1);
        chk("t5_hold_id", 64'(r_id), 64'd3);
        @(posedge clk);
        #1;
        rr_val = 1;
        wait_idle();
        // Reset in the middle of a DECERR burst
        ar(32'hF000_0000, 5'd4, 8'd3);
        tick(1);
        rst = 1;
        tick(1);
        rst = 0;
        @(negedge clk);
        chk("t6_rvalid_idle", 64'(r_valid), 64'd0);
        chk("t6_cnt_zero", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        rr_force = 0;
        ar(32'h4000_0010, 5'd5, 8'd3);
        wait_idle();
        // Random traffic across all decode regions
        rv_rand = 1;
        for (int i = 0; i < 60; i++) begin
            ar({4'($urandom), 28'($urandom)}, 5'($urandom), 8'($urandom_range(0, 3)));
            tick($urandom_range(0, 2));
        end
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
